// File: rtl/shift_rows_pipe_pkg.sv
// Shared AES helpers: ShiftRows offset table, legal-Nb check and state byte indexing.
// Also imported by the cipher round datapath.
package shift_rows_pipe_pkg;

  localparam int ROWS = 4;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael widens the row 2/3 shifts by one for the 256-bit block.
  function automatic int row_offset(input int nb, input int row);
    int off;
    off = row;
    if ((nb == 8) && (row >= 2)) off = row + 1;
    return off;
  endfunction

  // Column-major byte index; byte k sits at bits 8*k +: 8, bit 0 = MSB.
  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Pure combinational ShiftRows / InvShiftRows byte permutation for Nb columns.
module shift_rows_perm
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [0:NB*32-1] state_i,
  input  logic             inv_i,
  output logic [0:NB*32-1] state_o
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_perm: NB must be 4, 6 or 8");
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF   = row_offset(NB, r);
      localparam int SRC_F = (c + OFF) % NB;
      localparam int SRC_I = (c - OFF + NB) % NB;
      assign state_o[8*byte_idx(r, c) +: 8] = inv_i ? state_i[8*byte_idx(r, SRC_I) +: 8]
                                                    : state_i[8*byte_idx(r, SRC_F) +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows stage behind a 2-entry elastic buffer (output reg + skid reg).
// in_ready comes straight from the skid valid flop, so out_ready never reaches it combinationally.
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [0:NB*32-1] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [0:NB*32-1] out
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  logic [0:NB*32-1] perm_data;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [0:NB*32-1] out_data_q, out_data_d;
  logic [0:NB*32-1] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             accept;
  logic             drain;

  shift_rows_perm #(.NB(NB)) u_perm (
    .state_i (in),
    .inv_i   (in_inv),
    .state_o (perm_data)
  );

  assign accept = in_valid & ~skid_valid_q & ~flush;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      // A full skid blocks accept, so refilling from skid and taking new input are exclusive.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d = perm_data;
        out_tag_d  = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (out_valid_q) begin
        skid_data_d  = perm_data;
        skid_tag_d   = in_tag;
        skid_valid_d = 1'b1;
      end else begin
        out_data_d  = perm_data;
        out_tag_d   = in_tag;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload is qualified by the valid flags, so it carries no reset.
  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    out_tag_q   <= out_tag_d;
    skid_data_q <= skid_data_d;
    skid_tag_q  <= skid_tag_d;
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out       = out_data_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: NB=4 and NB=8 instances, queue scoreboard.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [3:0]   in_tag4, out_tag4;
  logic [0:127] in4, out4;

  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [3:0]   in_tag8, out_tag8;
  logic [0:255] in8, out8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit acc4, acc8;

  logic [0:127] q4_d[$];
  logic [3:0]   q4_t[$];
  logic [0:255] q8_d[$];
  logic [3:0]   q8_t[$];

  localparam logic [0:127] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4), .in_tag(in_tag4), .in(in4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_tag(out_tag4), .out(out4)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8), .in_tag(in_tag8), .in(in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_tag(out_tag8), .out(out8)
  );

  // Reference ShiftRows straight from the Rijndael definition; NB=4 states are left-aligned.
  function automatic logic [0:255] sr_model(input logic [0:255] s, input int nb, input bit inv);
    logic [0:255] o;
    int offs[4];
    int src;
    o = '0;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  // One clock: sample at negedge (score outputs, record accepts), return 1 after the posedge.
  task automatic tick();
    logic [0:255] m;
    logic [0:127] e4;
    logic [0:255] e8;
    logic [3:0]   t;
    @(negedge clk);
    acc4 = rst_n && in_valid4 && in_ready4 && !flush;
    acc8 = rst_n && in_valid8 && in_ready8 && !flush;
    if (rst_n && !flush) begin
      if (out_valid4 && out_ready4) begin
        checks++;
        if (q4_d.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected: got beat tag %h, required no beat", out_tag4);
        end else begin
          e4 = q4_d.pop_front();
          t  = q4_t.pop_front();
          if (out4 !== e4 || out_tag4 !== t) begin
            errors++;
            $display("FAIL sb4_beat: got %h tag %h, required %h tag %h", out4, out_tag4, e4, t);
          end
        end
      end
      if (out_valid8 && out_ready8) begin
        checks++;
        if (q8_d.size() == 0) begin
          errors++;
          $display("FAIL sb8_unexpected: got beat tag %h, required no beat", out_tag8);
        end else begin
          e8 = q8_d.pop_front();
          t  = q8_t.pop_front();
          if (out8 !== e8 || out_tag8 !== t) begin
            errors++;
            $display("FAIL sb8_beat: got %h tag %h, required %h tag %h", out8, out_tag8, e8, t);
          end
        end
      end
    end
    if (acc4) begin
      m = sr_model({in4, 128'h0}, 4, in_inv4);
      e4 = m[0:127];
      q4_d.push_back(e4);
      q4_t.push_back(in_tag4);
    end
    if (acc8) begin
      q8_d.push_back(sr_model(in8, 8, in_inv8));
      q8_t.push_back(in_tag8);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input bit sel8, input logic [0:255] d, input bit inv, input logic [3:0] tag);
    bit done;
    done = 1'b0;
    if (sel8) begin
      in_valid8 = 1'b1; in8 = d; in_inv8 = inv; in_tag8 = tag;
    end else begin
      in_valid4 = 1'b1; in4 = d[0:127]; in_inv4 = inv; in_tag4 = tag;
    end
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      done = sel8 ? acc8 : acc4;
    end
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: tag %h accepted=0, required accepted=1", tag);
    end
  endtask

  task automatic drain_all();
    for (int n = 0; n < 50 && (q4_d.size() != 0 || q8_d.size() != 0); n++) tick();
    checks++;
    if (q4_d.size() != 0 || q8_d.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d/%0d beats, required 0/0", q4_d.size(), q8_d.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks += 2;
    if (out_valid4 !== 1'b0 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b%b, required 00", out_valid4, out_valid8);
    end
    if (in_ready4 !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b, required 11", in_ready4, in_ready8);
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fips();
    out_ready4 = 1'b1;
    send(1'b0, {FIPS_IN, 128'h0}, 1'b0, 4'h1);
    checks++;
    if (out_valid4 !== 1'b1 || out4 !== FIPS_OUT || out_tag4 !== 4'h1) begin
      errors++;
      $display("FAIL fips_fwd: got v=%b %h tag %h, required v=1 %h tag 1", out_valid4, out4, out_tag4, FIPS_OUT);
    end
    send(1'b0, {FIPS_OUT, 128'h0}, 1'b1, 4'h2);
    checks++;
    if (out_valid4 !== 1'b1 || out4 !== FIPS_IN || out_tag4 !== 4'h2) begin
      errors++;
      $display("FAIL fips_inv: got v=%b %h tag %h, required v=1 %h tag 2", out_valid4, out4, out_tag4, FIPS_IN);
    end
    drain_all();
  endtask

  task automatic test_nb8();
    logic [0:255] seq, r8;
    for (int k = 0; k < 32; k++) seq[8*k +: 8] = 8'(k);
    out_ready8 = 1'b1;
    send(1'b1, seq, 1'b0, 4'h3);
    r8 = out8;
    checks += 3;
    if (out_valid8 !== 1'b1 || out8[0:31] !== 32'h00050e13) begin
      errors++;
      $display("FAIL nb8_col0: got v=%b %h, required v=1 00050e13", out_valid8, out8[0:31]);
    end
    if (out8[48 +: 8] !== 8'h12) begin
      errors++;
      $display("FAIL nb8_row2_offset: got %h, required 12", out8[48 +: 8]);
    end
    if (out8[56 +: 8] !== 8'h17) begin
      errors++;
      $display("FAIL nb8_row3_offset: got %h, required 17", out8[56 +: 8]);
    end
    send(1'b1, r8, 1'b1, 4'h4);
    checks++;
    if (out_valid8 !== 1'b1 || out8 !== seq) begin
      errors++;
      $display("FAIL nb8_roundtrip: got %h, required %h", out8, seq);
    end
    drain_all();
  endtask

  task automatic test_back_to_back();
    int start;
    out_ready4 = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'($urandom_range(0, 1)), 4'(i + 5));
      checks++;
      if (in_ready4 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready: beat %0d got %b, required 1", i, in_ready4);
      end
    end
    checks++;
    if (cyc - start != 8) begin
      errors++;
      $display("FAIL b2b_rate: got %0d cycles for 8 beats, required 8", cyc - start);
    end
    drain_all();
  endtask

  task automatic test_backpressure();
    bit done;
    out_ready4 = 1'b0;
    send(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0, 4'h1);
    send(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b1, 4'h2);
    checks++;
    if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1 || out_tag4 !== 4'h1) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b tag %h, required rdy=0 v=1 tag 1", in_ready4, out_valid4, out_tag4);
    end
    in_valid4 = 1'b1; in4 = {$urandom, $urandom, $urandom, $urandom}; in_inv4 = 1'b0; in_tag4 = 4'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1 || out_tag4 !== 4'h1 || acc4) begin
        errors++;
        $display("FAIL bp_hold: got rdy=%b v=%b tag %h acc=%b, required rdy=0 v=1 tag 1 acc=0", in_ready4, out_valid4, out_tag4, acc4);
      end
    end
    out_ready4 = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      tick();
      done = acc4;
    end
    in_valid4 = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_release: tag 3 accepted=0, required accepted=1");
    end
    drain_all();
  endtask

  task automatic test_flush();
    out_ready4 = 1'b0;
    send(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0, 4'h6);
    send(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0, 4'h7);
    flush = 1'b1;
    in_valid4 = 1'b1; in4 = {$urandom, $urandom, $urandom, $urandom}; in_tag4 = 4'hf;
    tick();
    flush = 1'b0;
    in_valid4 = 1'b0;
    q4_d.delete(); q4_t.delete(); q8_d.delete(); q8_t.delete();
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got v=%b rdy=%b, required v=0 rdy=1", out_valid4, in_ready4);
    end
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid4 !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost: got v=%b tag %h, required v=0", out_valid4, out_tag4);
      end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready4 = 1'b0;
    send(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0, 4'h8);
    send(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b1, 4'h9);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got v=%b rdy=%b, required v=0 rdy=1", out_valid4, in_ready4);
    end
    tick();
    #3 rst_n = 1'b1;
    q4_d.delete(); q4_t.delete(); q8_d.delete(); q8_t.delete();
    @(posedge clk);
    #1;
    out_ready4 = 1'b1;
    send(1'b0, {FIPS_IN, 128'h0}, 1'b0, 4'h5);
    checks++;
    if (out_valid4 !== 1'b1 || out_tag4 !== 4'h5 || out4 !== FIPS_OUT) begin
      errors++;
      $display("FAIL rst_first_beat: got v=%b tag %h, required v=1 tag 5", out_valid4, out_tag4);
    end
    drain_all();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    in_valid4 = 1'b0; in_inv4 = 1'b0; in_tag4 = '0; in4 = '0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; in_inv8 = 1'b0; in_tag8 = '0; in8 = '0; out_ready8 = 1'b1;
    test_reset();
    test_fips();
    test_nb8();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4: state columns (Rijndael Nb); legal values 4, 6, 8; other values fail elaboration.
REQ-002 SHALL have parameter TAG_W, default 4: sideband tag width; minimum 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1: synchronous clear of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1: input beat offered.
REQ-007 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-008 SHALL have port in_inv, input, 1: 0 = forward ShiftRows, 1 = InvShiftRows.
REQ-009 SHALL have port in_tag, input, TAG_W: sideband carried unchanged with the beat.
REQ-010 SHALL have port in, input, [0:NB*32-1]: state; byte (r,c) at bits 8*(4c+r) +: 8, bit 0 = MSB.
REQ-011 SHALL have port out_valid, output, 1: result beat offered.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts beat.
REQ-013 SHALL have port out_tag, output, TAG_W: tag of the presented beat.
REQ-014 SHALL have port out, output, [0:NB*32-1]: transformed state, same byte layout as in.

Function
REQ-015 SHALL use row offsets C0=0, C1=1, C2=2, C3=3 for NB=4 or 6, and C0=0, C1=1, C2=3, C3=4 for NB=8.
REQ-016 SHALL compute forward out(r,c) = in(r,(c+Cr) mod NB) and inverse out(r,c) = in(r,(c-Cr+NB) mod NB), with in_inv sampled per beat.
REQ-017 SHALL accept a beat on a cycle where in_valid and in_ready are both 1 and flush is 0, and transfer a beat on a cycle where out_valid and out_ready are both 1.
REQ-018 SHALL register the transformed data and tag, so out_valid rises on the edge that accepts the beat (latency 1 cycle) when the output slot is empty or draining.
REQ-019 SHALL implement a 2-entry elastic buffer: output register plus one skid register; in_ready = NOT skid_valid, driven from a flop with no combinational path from out_ready.
REQ-020 SHALL load the skid register on accept while the output is valid and not draining; the skid entry moves to the output on the next drain.
REQ-021 SHALL sustain 1 beat/cycle while out_ready is held at 1, and SHALL never drop, duplicate or reorder beats.
REQ-022 SHALL, on accept and drain in the same cycle with the skid register empty, replace the output register with the new beat and keep out_valid at 1.
REQ-023 SHALL hold out, out_tag and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when flush=1, clear both valid flags on the next edge and discard any concurrent input beat; flush overrides accept and drain.
REQ-025 SHALL leave data and tag registers un-reset; only the valid flags are reset.

Reset
REQ-026 SHALL, while rst_n=0, drive out_valid=0 and in_ready=1 and clear skid_valid, independent of clk.
REQ-027 SHALL discard any buffered beat when rst_n is asserted mid-operation; the first edge after deassertion can accept a beat.

Structure
REQ-028 SHALL take the offset table (function of NB and row), legal-NB check and byte-index helper from the shared AES package, which is also used by the cipher round.
REQ-029 SHALL place the pure combinational permutation (NB, in_inv) -> permuted state in a sub-module shift_rows_perm; shift_rows_pipe holds the buffer and control.

Verification
REQ-030 SHALL test FIPS-197 vector, NB=4, fwd: in = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> out = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5 one cycle later.
REQ-031 SHALL test the inverse of the same vector, in_inv=1, fed the REQ-030 output -> the original input is returned; with NB=8 and bytes 00..1f, forward then inverse restores 00..1f.
REQ-032 SHALL test NB=8, fwd, bytes 00..1f: out column 0 = 00 05 0e 13; row 2 and row 3 offsets confirmed as 3 and 4.
REQ-033 SHALL test backpressure: 3 back-to-back beats with tags 1, 2, 3 and out_ready=0 -> in_ready falls after 2 accepts; releasing out_ready -> tags 1, 2, 3 in order with no loss.
REQ-034 SHALL test a full buffer with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the concurrent beat never appears.
REQ-035 SHALL test rst_n pulsed low mid-stream, off a clock edge -> out_valid=0 immediately; after release the first beat emerges 1 cycle after accept.
